// File: rtl/fft_twiddle_fetch.sv
// Twiddle-factor fetcher: walks a strided ROM address per upstream sample strobe
// and returns the registered twiddle word two cycles after each fetch.
module fft_twiddle_fetch #(
    parameter int N_LOG2        = 10,
    parameter int ADDRESS_WIDTH = 9,
    parameter int DATA_WIDTH    = 10,
    parameter int STRIDE_LOG2   = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start_i,
    input  logic                            valid_i,
    input  logic signed [DATA_WIDTH-1:0]    rom_data_i,
    output logic                            rom_en_o,
    output logic                            rom_we_o,
    output logic        [ADDRESS_WIDTH-1:0] rom_addr_o,
    output logic signed [DATA_WIDTH-1:0]    twiddle_o,
    output logic                            valid_o,
    output logic                            last_o,
    output logic                            busy_o
);

    localparam int WIDE_W = N_LOG2 + STRIDE_LOG2 + ADDRESS_WIDTH;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t                          state_reg, state_next;
    logic        [N_LOG2-1:0]        ctr_reg, ctr_next;
    logic        [WIDE_W-1:0]        addr_wide;
    logic                            fetch;
    logic                            ctr_at_end;
    logic signed [DATA_WIDTH-1:0]    twiddle_reg;

    assign fetch      = rst_n && (state_reg == RUN) && valid_i;
    assign ctr_at_end = &ctr_reg;

    // Stage 0 tracks the ROM read in flight, stage 1 qualifies the output word.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pipe
            logic valid_reg;
            logic last_reg;
            logic valid_in;
            logic last_in;

            if (gi == 0) begin : g_head
                assign valid_in = fetch;
                assign last_in  = fetch && ctr_at_end;
            end else begin : g_tail
                assign valid_in = g_pipe[gi-1].valid_reg;
                assign last_in  = g_pipe[gi-1].last_reg;
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    last_reg  <= 1'b0;
                end else begin
                    valid_reg <= valid_in;
                    last_reg  <= last_in;
                end
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        ctr_next   = ctr_reg;
        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    state_next = RUN;
                    ctr_next   = '0;
                end
            end
            RUN: begin
                if (fetch) begin
                    ctr_next = ctr_reg + N_LOG2'(1);
                    if (ctr_at_end) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Stage 1 empties on this same edge, so both stages are clear in IDLE.
                if (!g_pipe[0].valid_reg) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            ctr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ctr_reg   <= ctr_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            twiddle_reg <= '0;
        end else if (g_pipe[0].valid_reg) begin
            twiddle_reg <= rom_data_i;
        end
    end

    assign addr_wide  = WIDE_W'(ctr_reg) << STRIDE_LOG2;
    assign rom_addr_o = rst_n ? addr_wide[ADDRESS_WIDTH-1:0] : '0;
    assign rom_en_o   = fetch;
    assign rom_we_o   = 1'b0;
    assign twiddle_o  = twiddle_reg;
    assign valid_o    = g_pipe[1].valid_reg;
    assign last_o     = g_pipe[1].last_reg;
    assign busy_o     = (state_reg != IDLE);

endmodule
